bus_sequencer: RTL and testbench

BUS_SEQUENCER -- requirements
Module: bus_sequencer

---
 rtl/bus_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_bus_sequencer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_sequencer.sv
// bus_sequencer: 8-bit multiplexed address/data bus master.
// Caches the high address byte and drives every pad from a register.
module bus_sequencer #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic        hi_flush,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [7:0]  bus_out,
  output logic        bus_drive,
  input  logic [7:0]  bus_in,
  output logic        le_hi,
  output logic        le_lo,
  output logic        oe_n,
  output logic        we_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_RD,
    S_WR
  } state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        hi_valid_q, hi_valid_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        le_hi_q, le_hi_d;
  logic        le_lo_q, le_lo_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        drive_q, drive_d;
  logic [7:0]  bus_q, bus_d;
  logic        accept;
  logic        hit;

  assign accept = req_valid && ready_q
               && (state_q == S_IDLE);
  // A flush in the same cycle as acceptance forces a miss.
  assign hit = hi_valid_q && !hi_flush
            && (req_addr[15:8] == hi_byte_q);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    hi_valid_d  = hi_valid_q;
    hi_byte_d   = hi_byte_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          state_d = hit ? S_LO : S_HI;
        end
      end
      S_HI: begin
        hi_valid_d = 1'b1;
        hi_byte_d  = addr_q[15:8];
        state_d    = S_LO;
      end
      S_LO: begin
        cnt_d   = WS;
        state_d = we_q ? S_WR : S_RD;
      end
      S_RD: begin
        if (cnt_q == 3'd0) begin
          rdata_d     = bus_in;
          rsp_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_WR: begin
        if (cnt_q == 3'd0) begin
          rsp_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (hi_flush) hi_valid_d = 1'b0;
  end

  // Pad values are decoded from the next state so they register
  // alongside it.
  always_comb begin
    ready_d = 1'b0;
    le_hi_d = 1'b0;
    le_lo_d = 1'b0;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    drive_d = 1'b0;
    bus_d   = 8'h00;
    unique case (state_d)
      S_IDLE: ready_d = 1'b1;
      S_HI: begin
        le_hi_d = 1'b1;
        drive_d = 1'b1;
        bus_d   = addr_d[15:8];
      end
      S_LO: begin
        le_lo_d = 1'b1;
        drive_d = 1'b1;
        bus_d   = addr_d[7:0];
      end
      S_RD: oe_n_d = 1'b0;
      S_WR: begin
        we_n_d  = 1'b0;
        drive_d = 1'b1;
        bus_d   = wdata_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= 16'h0000;
      we_q        <= 1'b0;
      wdata_q     <= 8'h00;
      cnt_q       <= 3'd0;
      hi_valid_q  <= 1'b0;
      hi_byte_q   <= 8'h00;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
      le_hi_q     <= 1'b0;
      le_lo_q     <= 1'b0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      drive_q     <= 1'b0;
      bus_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      hi_valid_q  <= hi_valid_d;
      hi_byte_q   <= hi_byte_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      le_hi_q     <= le_hi_d;
      le_lo_q     <= le_lo_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      drive_q     <= drive_d;
      bus_q       <= bus_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign bus_out   = bus_q;
  assign bus_drive = drive_q;
  assign le_hi     = le_hi_q;
  assign le_lo     = le_lo_q;
  assign oe_n      = oe_n_q;
  assign we_n      = we_n_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: directed bench driving two sequencers
// (0 and 2 wait states) from one shared request stream.
module tb_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic        hi_flush = 1'b0;
  logic [7:0]  bus_in = 8'h00;

  logic       rdy0, rv0, bd0, lh0, ll0, oe0, we0;
  logic [7:0] rdata0, bo0;
  logic       rdy2, rv2, bd2, lh2, ll2, oe2, we2;
  logic [7:0] rdata2, bo2;

  int checks = 0;
  int fails = 0;
  int acc0 = 0, acc2 = 0;
  int rspc0 = 0, rspc2 = 0;

  always #5 clk = ~clk;

  bus_sequencer #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(rdy0),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .hi_flush(hi_flush),
    .rsp_valid(rv0), .rsp_rdata(rdata0),
    .bus_out(bo0), .bus_drive(bd0), .bus_in(bus_in),
    .le_hi(lh0), .le_lo(ll0), .oe_n(oe0), .we_n(we0)
  );

  bus_sequencer #(.WAIT_STATES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(rdy2),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .hi_flush(hi_flush),
    .rsp_valid(rv2), .rsp_rdata(rdata2),
    .bus_out(bo2), .bus_drive(bd2), .bus_in(bus_in),
    .le_hi(lh2), .le_lo(ll2), .oe_n(oe2), .we_n(we2)
  );

  always @(posedge clk) begin
    if (rst_n && req_valid && rdy0) acc0++;
    if (rst_n && req_valid && rdy2) acc2++;
    if (rv0) rspc0++;
    if (rv2) rspc2++;
  end

  always @(negedge clk) begin
    checks++;
    if ($countones({lh0, ll0, ~oe0, ~we0}) > 1
        || (!oe0 && bd0)) begin
      fails++;
      $display("FAIL excl0 t=%0t lh=%b ll=%b oe_n=%b we_n=%b drv=%b",
               $time, lh0, ll0, oe0, we0, bd0);
    end
    checks++;
    if ($countones({lh2, ll2, ~oe2, ~we2}) > 1
        || (!oe2 && bd2)) begin
      fails++;
      $display("FAIL excl2 t=%0t lh=%b ll=%b oe_n=%b we_n=%b drv=%b",
               $time, lh2, ll2, oe2, we2, bd2);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!(rdy0 && rdy2) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(rdy0 && rdy2)) begin
      fails++;
      $display("FAIL wait_idle got rdy0=%b rdy2=%b want 1 1",
               rdy0, rdy2);
    end
  endtask

  task automatic issue(input logic we, input logic [15:0] a,
                       input logic [7:0] d, input logic fl);
    wait_idle();
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    hi_flush  = fl;
    @(negedge clk);
    req_valid = 1'b0;
    hi_flush  = 1'b0;
  endtask

  task automatic observe0(output int lat, output bit saw_hi,
                          output logic [7:0] hib,
                          output logic [7:0] rd);
    lat = 0;
    saw_hi = 1'b0;
    hib = 8'h00;
    rd = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (lh0) begin
        saw_hi = 1'b1;
        hib = bo0;
      end
      if (rv0) begin
        rd = rdata0;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy0, rv0, rdata0, bo0, bd0, lh0, ll0, oe0, we0}
        !== {1'b0, 1'b0, 8'h00, 8'h00, 5'b00011}) begin
      fails++;
      $display("FAIL reset_vals got %b want %b",
               {rdy0, rv0, rdata0, bo0, bd0, lh0, ll0, oe0, we0},
               {1'b0, 1'b0, 8'h00, 8'h00, 5'b00011});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdy0, rdy2} !== 2'b11) begin
      fails++;
      $display("FAIL ready_after_reset got %b want 11",
               {rdy0, rdy2});
    end
  endtask

  task automatic test_first_read();
    bus_in = 8'h04;
    issue(1'b0, 16'h0000, 8'h00, 1'b0);
    checks++;
    if ({lh0, ll0, bd0, rdy0, bo0} !== {4'b1010, 8'h00}) begin
      fails++;
      $display("FAIL first_hi got %b want %b",
               {lh0, ll0, bd0, rdy0, bo0}, {4'b1010, 8'h00});
    end
    @(negedge clk);
    checks++;
    if ({lh0, ll0, bd0, bo0} !== {3'b011, 8'h00}) begin
      fails++;
      $display("FAIL first_lo got %b want %b",
               {lh0, ll0, bd0, bo0}, {3'b011, 8'h00});
    end
    @(negedge clk);
    checks++;
    if ({oe0, bd0, rv0} !== 3'b000) begin
      fails++;
      $display("FAIL first_rd got %b want 000", {oe0, bd0, rv0});
    end
    @(negedge clk);
    checks++;
    if ({rv0, oe0, rdata0} !== {2'b11, 8'h04}) begin
      fails++;
      $display("FAIL first_rsp got %b want %b",
               {rv0, oe0, rdata0}, {2'b11, 8'h04});
    end
    @(negedge clk);
    checks++;
    if (rv0 !== 1'b0) begin
      fails++;
      $display("FAIL rsp_pulse got %b want 0", rv0);
    end
  endtask

  task automatic test_seq_reads();
    int lat;
    bit sh;
    logic [7:0] hb, rd;
    bus_in = 8'h11;
    issue(1'b0, 16'h0001, 8'h00, 1'b0);
    observe0(lat, sh, hb, rd);
    checks++;
    if (lat != 2 || sh || rd !== 8'h11) begin
      fails++;
      $display("FAIL seq_0001 got lat=%0d hi=%b rd=%h want 2 0 11",
               lat, sh, rd);
    end
    bus_in = 8'h22;
    issue(1'b0, 16'h0002, 8'h00, 1'b0);
    observe0(lat, sh, hb, rd);
    checks++;
    if (lat != 2 || sh || rd !== 8'h22) begin
      fails++;
      $display("FAIL seq_0002 got lat=%0d hi=%b rd=%h want 2 0 22",
               lat, sh, rd);
    end
    bus_in = 8'h33;
    issue(1'b0, 16'h0100, 8'h00, 1'b0);
    observe0(lat, sh, hb, rd);
    checks++;
    if (lat != 3 || !sh || hb !== 8'h01 || rd !== 8'h33) begin
      fails++;
      $display("FAIL seq_0100 got lat=%0d hi=%b hb=%h rd=%h want 3 1 01 33",
               lat, sh, hb, rd);
    end
  endtask

  task automatic test_back_to_back();
    int a0, a2, r0, r2;
    bus_in = 8'h5A;
    wait_idle();
    @(negedge clk);
    a0 = acc0;
    a2 = acc2;
    r0 = rspc0;
    r2 = rspc2;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0105;
    repeat (15) @(negedge clk);
    req_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    checks++;
    if (acc0 - a0 != 5 || rspc0 - r0 != 5) begin
      fails++;
      $display("FAIL b2b_dut0 got acc=%0d rsp=%0d want 5 5",
               acc0 - a0, rspc0 - r0);
    end
    checks++;
    if (acc2 - a2 != 3 || rspc2 - r2 != 3) begin
      fails++;
      $display("FAIL b2b_dut2 got acc=%0d rsp=%0d want 3 3",
               acc2 - a2, rspc2 - r2);
    end
  endtask

  task automatic test_wait_write();
    issue(1'b1, 16'hC703, 8'h69, 1'b0);
    checks++;
    if ({lh2, bd2, bo2} !== {2'b11, 8'hC7}) begin
      fails++;
      $display("FAIL ww_hi got %b want %b",
               {lh2, bd2, bo2}, {2'b11, 8'hC7});
    end
    @(negedge clk);
    checks++;
    if ({ll2, bd2, bo2} !== {2'b11, 8'h03}) begin
      fails++;
      $display("FAIL ww_lo got %b want %b",
               {ll2, bd2, bo2}, {2'b11, 8'h03});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({we2, oe2, bd2, rv2, bo2} !== {4'b0110, 8'h69}) begin
        fails++;
        $display("FAIL ww_strobe%0d got %b want %b", i,
                 {we2, oe2, bd2, rv2, bo2}, {4'b0110, 8'h69});
      end
    end
    @(negedge clk);
    checks++;
    if ({we2, rv2, bd2} !== 3'b110) begin
      fails++;
      $display("FAIL ww_done got %b want 110", {we2, rv2, bd2});
    end
    checks++;
    if (rdata0 !== 8'h5A || rdata2 !== 8'h5A) begin
      fails++;
      $display("FAIL rdata_hold got %h %h want 5a 5a",
               rdata0, rdata2);
    end
  endtask

  task automatic test_flush();
    int lat;
    bit sh;
    logic [7:0] hb, rd;
    issue(1'b0, 16'h8000, 8'h00, 1'b0);
    observe0(lat, sh, hb, rd);
    issue(1'b0, 16'h8009, 8'h00, 1'b0);
    observe0(lat, sh, hb, rd);
    checks++;
    if (sh || lat != 2) begin
      fails++;
      $display("FAIL fl_hit got hi=%b lat=%0d want 0 2", sh, lat);
    end
    wait_idle();
    hi_flush = 1'b1;
    @(negedge clk);
    hi_flush = 1'b0;
    issue(1'b0, 16'h8008, 8'h00, 1'b0);
    observe0(lat, sh, hb, rd);
    checks++;
    if (!sh || hb !== 8'h80 || lat != 3) begin
      fails++;
      $display("FAIL fl_pulse got hi=%b hb=%h lat=%0d want 1 80 3",
               sh, hb, lat);
    end
    issue(1'b0, 16'h800A, 8'h00, 1'b1);
    observe0(lat, sh, hb, rd);
    checks++;
    if (!sh || hb !== 8'h80) begin
      fails++;
      $display("FAIL fl_coincident got hi=%b hb=%h want 1 80", sh, hb);
    end
    issue(1'b0, 16'h800B, 8'h00, 1'b0);
    observe0(lat, sh, hb, rd);
    checks++;
    if (sh) begin
      fails++;
      $display("FAIL fl_recache got hi=%b want 0", sh);
    end
    issue(1'b0, 16'h8100, 8'h00, 1'b0);
    hi_flush = 1'b1;
    @(negedge clk);
    hi_flush = 1'b0;
    issue(1'b0, 16'h8101, 8'h00, 1'b0);
    observe0(lat, sh, hb, rd);
    checks++;
    if (!sh || hb !== 8'h81) begin
      fails++;
      $display("FAIL fl_during_hi got hi=%b hb=%h want 1 81", sh, hb);
    end
  endtask

  task automatic test_wrap();
    int lat;
    bit sh;
    logic [7:0] hb, rd;
    issue(1'b0, 16'hFFFF, 8'h00, 1'b0);
    observe0(lat, sh, hb, rd);
    issue(1'b0, 16'h0000, 8'h00, 1'b0);
    observe0(lat, sh, hb, rd);
    checks++;
    if (!sh || hb !== 8'h00 || lat != 3) begin
      fails++;
      $display("FAIL wrap got hi=%b hb=%h lat=%0d want 1 00 3",
               sh, hb, lat);
    end
  endtask

  task automatic test_reset_mid_wr();
    int r0, r2, lat;
    bit sh;
    logic [7:0] hb, rd;
    issue(1'b1, 16'h1234, 8'hAB, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if ({we0, we2} !== 2'b00) begin
      fails++;
      $display("FAIL mid_wr_entry got %b want 00", {we0, we2});
    end
    r0 = rspc0;
    r2 = rspc2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({we0, bd0, we2, bd2, bo0, rdata0} !== {4'b1010, 16'h0000}) begin
      fails++;
      $display("FAIL async_reset got %b want %b",
               {we0, bd0, we2, bd2, bo0, rdata0},
               {4'b1010, 16'h0000});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (rspc0 != r0 || rspc2 != r2) begin
      fails++;
      $display("FAIL abort_rsp got %0d %0d want 0 0",
               rspc0 - r0, rspc2 - r2);
    end
    issue(1'b0, 16'h1234, 8'h00, 1'b0);
    observe0(lat, sh, hb, rd);
    checks++;
    if (!sh || hb !== 8'h12) begin
      fails++;
      $display("FAIL post_reset_hi got hi=%b hb=%h want 1 12", sh, hb);
    end
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_seq_reads();
    test_back_to_back();
    test_wait_write();
    test_flush();
    test_wrap();
    test_reset_mid_wr();
    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
